// File: rtl/fwd_hazard_unit_if.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit_if
// Purpose : bundles the decode-stage request and the bypass/stall response
//           exchanged between the pipeline control and fwd_hazard_unit.
// Signals :
//   id_valid    decode holds a valid instruction
//   id_ins      decode instruction word (rs = [25:21], rt = [20:16])
//   id_wr_en    decode instruction writes a register
//   id_wr_addr  its destination register
//   id_is_load  decode instruction is a load
//   flush       squash all in-flight entries
//   sel_a/sel_b bypass select for rs/rt (0 = register file, k = stage k)
//   stall       hold fetch/decode, bubble issued this cycle
//   stall_cnt   saturating count of stall cycles
// Modports: master = pipeline control side, slave = hazard unit side.
// ---------------------------------------------------------------------------
interface fwd_hazard_unit_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2,
  parameter int SEL_W  = $clog2(DEPTH + 1)
);
  logic              id_valid;
  logic [DATA_W-1:0] id_ins;
  logic              id_wr_en;
  logic [REG_AW-1:0] id_wr_addr;
  logic              id_is_load;
  logic              flush;
  logic [SEL_W-1:0]  sel_a;
  logic [SEL_W-1:0]  sel_b;
  logic              stall;
  logic [15:0]       stall_cnt;

  modport master (
    output id_valid, id_ins, id_wr_en, id_wr_addr, id_is_load, flush,
    input  sel_a, sel_b, stall, stall_cnt
  );

  modport slave (
    input  id_valid, id_ins, id_wr_en, id_wr_addr, id_is_load, flush,
    output sel_a, sel_b, stall, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
// Purpose : forwarding and load-use hazard detection for the MIPS pipeline.
//           A DEPTH-stage shift-register scoreboard records in-flight
//           register writes (stage 1 = youngest). For each decode source
//           operand the youngest matching producer picks the bypass source;
//           if that producer is a load whose data is not ready yet, a stall
//           is raised and a bubble is pushed into the scoreboard.
// Ports   :
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears scoreboard and counter)
//   bus    fwd_hazard_unit_if.slave (decode request in, selects/stall out)
// Parameters:
//   DATA_W   instruction width
//   REG_AW   register address width
//   DEPTH    number of tracked in-flight write stages (>= 1)
//   LOAD_LAT a load in stage k is ready only when k > LOAD_LAT
//   SEL_W    select width, derived from DEPTH
// ---------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = $clog2(DEPTH + 1)
) (
  input logic              clk,
  input logic              rst_n,
  fwd_hazard_unit_if.slave bus
);

  // Scoreboard, index gi holds stage gi+1.
  logic [DEPTH-1:0]             r_v;
  logic [DEPTH-1:0][REG_AW-1:0] r_addr;
  logic [DEPTH-1:0]             r_ld;
  logic [15:0]                  r_stall_cnt;

  logic [REG_AW-1:0] w_rs;
  logic [REG_AW-1:0] w_rt;
  logic [DEPTH-1:0]  w_ready;
  logic [DEPTH-1:0]  w_match_a;
  logic [DEPTH-1:0]  w_match_b;
  logic [SEL_W-1:0]  w_sel_a;
  logic [SEL_W-1:0]  w_sel_b;
  logic              w_haz_a;
  logic              w_haz_b;
  logic              w_stall;
  logic              w_push_v;
  logic              w_unused_ins;

  assign w_rs = REG_AW'(bus.id_ins[25:21]);
  assign w_rt = REG_AW'(bus.id_ins[20:16]);

  // Only the rs/rt fields of the instruction word matter here.
  assign w_unused_ins = ^{bus.id_ins[DATA_W-1:26], bus.id_ins[15:0]};

  // Per-stage readiness and source matching. Readiness of a load depends
  // only on its stage position, so the stage test folds to a constant.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      localparam bit STAGE_LOAD_READY = (gi + 1) > LOAD_LAT;

      assign w_ready[gi]   = !r_ld[gi] || STAGE_LOAD_READY;
      // Register 0 is hard-wired zero and is never a forwarding target.
      assign w_match_a[gi] = r_v[gi] && (r_addr[gi] == w_rs) && (w_rs != '0);
      assign w_match_b[gi] = r_v[gi] && (r_addr[gi] == w_rt) && (w_rt != '0);
    end
  endgenerate

  // Youngest-match priority: walk from the oldest stage to the youngest so
  // the last hit (lowest stage) wins and shadows every older match, even a
  // ready one. A not-ready youngest match reads the register file (sel 0)
  // and flags a hazard instead.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    w_haz_a = 1'b0;
    w_haz_b = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (w_match_a[k]) begin
        w_sel_a = w_ready[k] ? SEL_W'(k + 1) : '0;
        w_haz_a = !w_ready[k];
      end
      if (w_match_b[k]) begin
        w_sel_b = w_ready[k] ? SEL_W'(k + 1) : '0;
        w_haz_b = !w_ready[k];
      end
    end
  end

  // A flush squashes the decode instruction too, so it never stalls.
  assign w_stall = bus.id_valid && (w_haz_a || w_haz_b) && !bus.flush;

  // Stage 1 receives the decode write only when it actually issues; a stall
  // or an empty decode slot becomes a bubble.
  assign w_push_v = bus.id_valid && !w_stall && bus.id_wr_en &&
                    (bus.id_wr_addr != '0);

  // Outputs are combinational; the scoreboard reset clears every match, so
  // the selects and stall drop to zero as soon as rst_n falls.
  assign bus.sel_a     = bus.id_valid ? w_sel_a : '0;
  assign bus.sel_b     = bus.id_valid ? w_sel_b : '0;
  assign bus.stall     = w_stall;
  assign bus.stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v    <= '0;
      r_addr <= '0;
      r_ld   <= '0;
    end else if (bus.flush) begin
      r_v <= '0;
    end else begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        r_v[k]    <= r_v[k-1];
        r_addr[k] <= r_addr[k-1];
        r_ld[k]   <= r_ld[k-1];
      end
      r_v[0]    <= w_push_v;
      r_addr[0] <= bus.id_wr_addr;
      r_ld[0]   <= bus.id_is_load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_unit
// Three hazard units share one decode stimulus stream:
//   u0: DEPTH=2,  LOAD_LAT=1  (defaults)
//   u1: DEPTH=3,  LOAD_LAT=2  (parameter sweep)
//   u2: DEPTH=32, LOAD_LAT=31 (long stall runs, used to saturate stall_cnt)
// Each step drives decode at the falling edge, queues the expected outputs
// for the selected instance and compares them shortly afterwards.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        t_valid;
  logic [31:0] t_ins;
  logic        t_wr_en;
  logic [4:0]  t_wr_addr;
  logic        t_is_load;
  logic        t_flush;

  fwd_hazard_unit_if #(.DATA_W(32), .REG_AW(5), .DEPTH(2))  bus0 ();
  fwd_hazard_unit_if #(.DATA_W(32), .REG_AW(5), .DEPTH(3))  bus1 ();
  fwd_hazard_unit_if #(.DATA_W(32), .REG_AW(5), .DEPTH(32)) bus2 ();

  assign bus0.id_valid = t_valid;   assign bus1.id_valid = t_valid;   assign bus2.id_valid = t_valid;
  assign bus0.id_ins = t_ins;       assign bus1.id_ins = t_ins;       assign bus2.id_ins = t_ins;
  assign bus0.id_wr_en = t_wr_en;   assign bus1.id_wr_en = t_wr_en;   assign bus2.id_wr_en = t_wr_en;
  assign bus0.id_wr_addr = t_wr_addr; assign bus1.id_wr_addr = t_wr_addr; assign bus2.id_wr_addr = t_wr_addr;
  assign bus0.id_is_load = t_is_load; assign bus1.id_is_load = t_is_load; assign bus2.id_is_load = t_is_load;
  assign bus0.flush = t_flush;      assign bus1.flush = t_flush;      assign bus2.flush = t_flush;

  fwd_hazard_unit #(.DATA_W(32), .REG_AW(5), .DEPTH(2),  .LOAD_LAT(1))
    u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  fwd_hazard_unit #(.DATA_W(32), .REG_AW(5), .DEPTH(3),  .LOAD_LAT(2))
    u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  fwd_hazard_unit #(.DATA_W(32), .REG_AW(5), .DEPTH(32), .LOAD_LAT(31))
    u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int checks = 0;
  int errors = 0;

  typedef struct {
    string tag;
    int    inst;
    int    sa;
    int    sb;
    int    st;
  } exp_t;

  exp_t sb_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic read_out(input int inst, output logic [31:0] sa, output logic [31:0] sb,
                          output logic [31:0] st, output logic [31:0] cnt);
    case (inst)
      0: begin
        sa = 32'(bus0.sel_a); sb = 32'(bus0.sel_b); st = 32'(bus0.stall); cnt = 32'(bus0.stall_cnt);
      end
      1: begin
        sa = 32'(bus1.sel_a); sb = 32'(bus1.sel_b); st = 32'(bus1.stall); cnt = 32'(bus1.stall_cnt);
      end
      default: begin
        sa = 32'(bus2.sel_a); sb = 32'(bus2.sel_b); st = 32'(bus2.stall); cnt = 32'(bus2.stall_cnt);
      end
    endcase
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic we, input logic [4:0] wa, input logic ld, input logic fl);
    t_valid   = v;
    t_ins     = {6'd0, rs, rt, 16'h1234};
    t_wr_en   = we;
    t_wr_addr = wa;
    t_is_load = ld;
    t_flush   = fl;
  endtask

  // One decode cycle: drive at the falling edge, queue the expectation,
  // then pop and compare before the next rising edge.
  task automatic step(input string tag, input int inst,
                      input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic we, input logic [4:0] wa, input logic ld, input logic fl,
                      input int esa, input int esb, input int est);
    exp_t e;
    exp_t h;
    logic [31:0] gsa, gsb, gst, gcnt;
    @(negedge clk);
    drive(v, rs, rt, we, wa, ld, fl);
    e.tag = tag; e.inst = inst; e.sa = esa; e.sb = esb; e.st = est;
    sb_q.push_back(e);
    #1;
    h = sb_q.pop_front();
    read_out(h.inst, gsa, gsb, gst, gcnt);
    $display("txn %s u%0d rs=%0d rt=%0d sel_a=%0d sel_b=%0d stall=%0d cnt=%0d",
             h.tag, h.inst, rs, rt, gsa, gsb, gst, gcnt);
    check_eq({h.tag, ".sel_a"}, gsa, 32'(h.sa));
    check_eq({h.tag, ".sel_b"}, gsb, 32'(h.sb));
    check_eq({h.tag, ".stall"}, gst, 32'(h.st));
  endtask

  task automatic check_cnt(input string tag, input int inst, input int exp);
    logic [31:0] gsa, gsb, gst, gcnt;
    read_out(inst, gsa, gsb, gst, gcnt);
    $display("txn %s u%0d stall_cnt=%0d", tag, inst, gcnt);
    check_eq(tag, gcnt, 32'(exp));
  endtask

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_cnt("rst.cnt_u0", 0, 0);
    check_cnt("rst.cnt_u1", 1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    //              tag          u  v  rs  rt  we  wa  ld fl  sa sb st
    // ALU forwarding from stage 1, then stage 2
    step("alu.wr8",    0, 1, 0,  0,  1, 8,  0, 0,  0, 0, 0);
    step("alu.use1",   0, 1, 8,  8,  0, 0,  0, 0,  1, 1, 0);
    step("alu.use2",   0, 1, 8,  8,  0, 0,  0, 0,  2, 2, 0);
    // Load-use: one stall cycle then forward from stage 2
    step("ld.wr9",     0, 1, 0,  0,  1, 9,  1, 0,  0, 0, 0);
    step("ld.stall",   0, 1, 0,  9,  0, 0,  0, 0,  0, 0, 1);
    step("ld.fwd",     0, 1, 0,  9,  0, 0,  0, 0,  0, 2, 0);
    check_cnt("ld.cnt", 0, 1);
    // Youngest wins: load in stage 1 shadows ALU in stage 2
    step("yw.alu5",    0, 1, 0,  0,  1, 5,  0, 0,  0, 0, 0);
    step("yw.ld5",     0, 1, 0,  0,  1, 5,  1, 0,  0, 0, 0);
    step("yw.stall",   0, 1, 5,  0,  0, 0,  0, 0,  0, 0, 1);
    step("yw.fwd",     0, 1, 5,  0,  0, 0,  0, 0,  2, 0, 0);
    // r0 is never forwarded, even from a load
    step("r0.wr",      0, 1, 0,  0,  1, 0,  1, 0,  0, 0, 0);
    step("r0.use",     0, 1, 0,  0,  0, 0,  0, 0,  0, 0, 0);
    // Flush suppresses the stall and clears the table
    step("fl.ld3",     0, 1, 0,  0,  1, 3,  1, 0,  0, 0, 0);
    step("fl.flush",   0, 1, 0,  3,  0, 0,  0, 1,  0, 0, 0);
    step("fl.after",   0, 1, 0,  3,  0, 0,  0, 0,  0, 0, 0);
    check_cnt("fl.cnt", 0, 1 + 1);
    // Invalid decode: zero outputs and a bubble
    step("iv.wr7",     0, 1, 0,  0,  1, 7,  0, 0,  0, 0, 0);
    step("iv.idle",    0, 0, 7,  7,  0, 0,  0, 0,  0, 0, 0);
    step("iv.use",     0, 1, 7,  0,  0, 0,  0, 0,  2, 0, 0);
    // rs and rt resolved independently against different stages
    step("ab.wr10",    0, 1, 0,  0,  1, 10, 0, 0,  0, 0, 0);
    step("ab.ld11",    0, 1, 0,  0,  1, 11, 1, 0,  0, 0, 0);
    step("ab.stall",   0, 1, 10, 11, 0, 0,  0, 0,  2, 0, 1);
    step("ab.fwd",     0, 1, 10, 11, 0, 0,  0, 0,  0, 2, 0);
    check_cnt("ab.cnt", 0, 3);

    // Asynchronous reset in the middle of a stall
    step("rs.ld9",     0, 1, 0,  0,  1, 9,  1, 0,  0, 0, 0);
    step("rs.stall",   0, 1, 9,  0,  0, 0,  0, 0,  0, 0, 1);
    #1 rst_n = 1'b0;
    #1;
    begin
      logic [31:0] gsa, gsb, gst, gcnt;
      read_out(0, gsa, gsb, gst, gcnt);
      $display("txn rs.async u0 sel_a=%0d sel_b=%0d stall=%0d cnt=%0d", gsa, gsb, gst, gcnt);
      check_eq("rs.async.sel_a", gsa, 32'd0);
      check_eq("rs.async.sel_b", gsb, 32'd0);
      check_eq("rs.async.stall", gst, 32'd0);
      check_eq("rs.async.cnt",   gcnt, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 1; r < 32; r++) begin
      step($sformatf("rs.nomatch%0d", r), 0, 1, 5'(r), 5'(32 - r), 0, 0, 0, 0, 0, 0, 0);
    end

    // Parameter sweep DEPTH=3, LOAD_LAT=2: two stall cycles then stage 3
    step("sw.ld4",     1, 1, 0,  0,  1, 4,  1, 0,  0, 0, 0);
    step("sw.stall1",  1, 1, 4,  0,  0, 0,  0, 0,  0, 0, 1);
    step("sw.stall2",  1, 1, 4,  0,  0, 0,  0, 0,  0, 0, 1);
    step("sw.fwd",     1, 1, 4,  0,  0, 0,  0, 0,  3, 0, 0);
    check_cnt("sw.cnt", 1, 2);

    // Chained dependent loads on u2 stall 31 of every 32 cycles; run long
    // enough to pass 65535 stalls, then confirm the counter holds.
    @(negedge clk);
    drive(1'b1, 5'd4, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0);
    repeat (67800) @(posedge clk);
    @(negedge clk);
    #1;
    check_cnt("sat.reach", 2, 16'hFFFF);
    repeat (200) @(negedge clk);
    #1;
    check_cnt("sat.hold", 2, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the MIPS pipeline. It keeps a shift-register scoreboard of in-flight register writes, DEPTH stages deep. Each cycle it selects a bypass source for both source operands (rs, rt) of the instruction in decode. When the youngest matching producer's result is not yet available (a load), it raises a stall, inserts a bubble and counts the stall cycles.

## Interface
Parameters:
- DATA_W, 32: instruction width; rs = [25:21], rt = [20:16]
- REG_AW, 5: register address width
- DEPTH, 2: number of in-flight write stages tracked (≥1); stage 1 is youngest
- LOAD_LAT, 1: a load in stage k has data ready only when k > LOAD_LAT; legal range 0..DEPTH-1
- SEL_W, $clog2(DEPTH+1): width of the select outputs (derived)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  decode holds a valid instruction
- id_ins  in  DATA_W  decode instruction word
- id_wr_en  in  1  decode instruction writes a register
- id_wr_addr  in  REG_AW  its destination register
- id_is_load  in  1  decode instruction is a load
- flush  in  1  squash all in-flight entries (branch/jump redirect)
- sel_a  out  SEL_W  rs source: 0 = register file, k = stage k result
- sel_b  out  SEL_W  rt source, same encoding as sel_a
- stall  out  1  hold fetch/decode; a bubble is issued this cycle
- stall_cnt  out  16  saturating count of stall cycles

## Operation
- Scoreboard entry per stage k: {v, addr[REG_AW-1:0], ld}.
  - An entry matches source s when v && addr == s && s != 0.
  - Register 0 never matches.
- Ready rule: an entry is ready when !ld || k > LOAD_LAT.
- Operand select, for each of rs and rt independently:
  - Find the youngest (lowest k) matching entry.
  - If none matches: sel = 0.
  - If one matches and it is ready: sel = k.
  - If one matches and it is not ready: sel = 0 and a hazard is flagged for that operand.
  - Older matches are shadowed by the youngest match, even when the older entry is ready.
- stall = id_valid && (hazard_a || hazard_b) && !flush.
  - Both fields are compared unconditionally, so the check is conservative.
- When id_valid = 0: sel_a = sel_b = 0 and stall = 0.
- Table update at each posedge, in priority order:
  1. flush: every v cleared.
  2. Otherwise shift: stage k+1 ← stage k, and the old stage DEPTH is discarded. Stage 1 is then loaded as follows:
     - stall = 1: stage 1 ← bubble (v = 0).
     - id_valid && !stall: stage 1 ← {id_wr_en && id_wr_addr != 0, id_wr_addr, id_is_load}.
     - !id_valid: stage 1 ← bubble.
- stall_cnt increments on each posedge where stall = 1 and saturates at 16'hFFFF.
- Reset (rst_n = 0, any time, including mid-stall): all v = 0, stall_cnt = 0.
  - The outputs become sel_a = sel_b = 0 and stall = 0 immediately, without waiting for clk.

## Timing
- sel_a, sel_b and stall are combinational from the decode inputs and the current table. Their values are valid in the same cycle.
- Scoreboard and stall_cnt are registered, with 1 cycle from input to table effect.
- A load-use stall lasts LOAD_LAT − k + 1 cycles, where k is the stage the load occupies when the dependency is first seen. With defaults, a back-to-back load-use pair stalls for exactly 1 cycle, then forwards from stage 2.
- Simultaneous events:
  - flush with a hazard: stall = 0 and the table is cleared at that edge.
  - rs and rt matching different stages: each select is resolved independently; stall is the OR of the two hazards.
- Upstream holds id_* stable while stall = 1. The block does not latch the decode instruction.

## Test plan
- Reset / idle:
  - Stimulus: assert rst_n = 0 mid-run with a load in stage 1.
  - Required: sel_a = sel_b = 0, stall = 0 and stall_cnt = 0 asynchronously; after release, no match occurs for any register.
- ALU forwarding:
  - Stimulus: issue a write to r8 (non-load), then an instruction with rs = 8 and rt = 8.
  - Required: sel_a = sel_b = 1. One further cycle later, with a non-writing instruction in between, sel = 2.
- Load-use (defaults):
  - Stimulus: issue a load to r9, then an instruction with rt = 9.
  - Required: stall = 1 for one cycle with sel_b = 0, then sel_b = 2 and stall = 0; stall_cnt = 1.
- Youngest-wins:
  - Stimulus: write r5 (ALU), then write r5 (load), then use rs = 5.
  - Required: stall = 1 (stage 1 is a load and shadows stage 2), then sel_a = 2.
- r0 and flush:
  - Stimulus (r0): write r0, then use rs = 0. Required: sel_a = 0, no stall.
  - Stimulus (flush): load r3, then assert flush in the cycle that uses rt = 3. Required: stall = 0, and the next cycle sel_b = 0.
- Parameter sweep:
  - Stimulus: DEPTH = 3, LOAD_LAT = 2; load r4, then use rs = 4.
  - Required: 2 stall cycles, then sel_a = 3; drive stall_cnt to saturation and check it holds at 16'hFFFF.
